// File: rtl/im_loader_if.sv
// Word-in / byte-out bus of the instruction-memory loader.
// The master side offers words and the slave side (the loader) drives the byte-write port.
interface im_loader_if #(
  parameter int unsigned CNT_W = 6
);
  logic             Start;
  logic             WordValid;
  logic [31:0]      WordData;
  logic             WordLast;
  logic             WordReady;
  logic             MemWe;
  logic [31:0]      MemAddr;
  logic [7:0]       MemData;
  logic             Busy;
  logic             Done;
  logic             Overflow;
  logic [CNT_W-1:0] WordCount;

  modport master (
    output Start, WordValid, WordData, WordLast,
    input  WordReady, MemWe, MemAddr, MemData, Busy, Done, Overflow, WordCount
  );

  modport slave (
    input  Start, WordValid, WordData, WordLast,
    output WordReady, MemWe, MemAddr, MemData, Busy, Done, Overflow, WordCount
  );
endinterface

// File: rtl/im_loader.sv
// Serialises 32-bit instruction words into big-endian byte writes starting at address 0.
// Every output is a register; one word takes one accept cycle plus four write cycles.
module im_loader #(
  parameter int unsigned MEM_SIZE = 128,
  parameter int unsigned CNT_W    = 6
) (
  input logic        clk,
  input logic        rst,
  im_loader_if.slave bus
);

  localparam int unsigned LW = $clog2(MEM_SIZE);
  localparam int unsigned PW = LW + 1;

  typedef enum logic [1:0] {StIdle, StAccept, StWrite, StDone} state_e;

  state_e           state_q;
  logic [PW-1:0]    ptr_q;
  logic [1:0]       idx_q;
  logic [31:0]      word_q;
  logic             last_q;
  logic             ready_q;
  logic             we_q;
  logic [LW-1:0]    addr_q;
  logic [7:0]       data_q;
  logic             busy_q;
  logic             done_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;

  logic [1:0]    idx_nxt;
  logic [LW-1:0] addr_nxt;
  logic [PW-1:0] ptr_nxt;
  logic          mem_full;

  function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] i);
    logic [7:0] b;
    b = w[7:0];
    unique case (i)
      2'd0: b = w[31:24];
      2'd1: b = w[23:16];
      2'd2: b = w[15:8];
      2'd3: b = w[7:0];
    endcase
    return b;
  endfunction

  always_comb begin
    idx_nxt  = idx_q + 2'd1;
    addr_nxt = ptr_q[LW-1:0] + LW'(idx_nxt);
    ptr_nxt  = ptr_q + PW'(4);
    mem_full = (ptr_q == PW'(MEM_SIZE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      last_q  <= 1'b0;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.Start) begin
            state_q <= StAccept;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        StAccept: begin
          // ready_q is always 1 here, so WordValid alone completes the handshake.
          if (bus.WordValid) begin
            state_q <= StWrite;
            word_q  <= bus.WordData;
            last_q  <= bus.WordLast;
            idx_q   <= 2'd0;
            ready_q <= 1'b0;
            we_q    <= 1'b1;
            addr_q  <= ptr_q[LW-1:0];
            data_q  <= bus.WordData[31:24];
          end
        end
        StWrite: begin
          if (idx_q == 2'd3) begin
            ptr_q <= ptr_nxt;
            cnt_q <= cnt_q + CNT_W'(1);
            we_q  <= 1'b0;
            if (last_q || (ptr_nxt == PW'(MEM_SIZE))) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= StAccept;
              ready_q <= 1'b1;
            end
          end else begin
            idx_q  <= idx_nxt;
            addr_q <= addr_nxt;
            data_q <= get_byte(word_q, idx_nxt);
          end
        end
        StDone: begin
          if (bus.Start) begin
            state_q <= StAccept;
            ptr_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b1;
          end else if (bus.WordValid && mem_full) begin
            ovf_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.WordReady = ready_q;
  assign bus.MemWe     = we_q;
  assign bus.MemAddr   = 32'(addr_q);
  assign bus.MemData   = data_q;
  assign bus.Busy      = busy_q;
  assign bus.Done      = done_q;
  assign bus.Overflow  = ovf_q;
  assign bus.WordCount = cnt_q;

endmodule

// File: tb/tb_im_loader.sv
// Directed bench for im_loader: single word, multi-word, fill/overflow, gaps, reset, Start races.
module tb_im_loader;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  im_loader_if #(.CNT_W(6)) bus ();

  im_loader #(
    .MEM_SIZE(128),
    .CNT_W   (6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, ".ready"}, 32'(bus.WordReady), 32'd0);
    chk({tag, ".we"},    32'(bus.MemWe),     32'd0);
    chk({tag, ".addr"},  bus.MemAddr,        32'd0);
    chk({tag, ".data"},  32'(bus.MemData),   32'd0);
    chk({tag, ".busy"},  32'(bus.Busy),      32'd0);
    chk({tag, ".done"},  32'(bus.Done),      32'd0);
    chk({tag, ".ovf"},   32'(bus.Overflow),  32'd0);
    chk({tag, ".cnt"},   32'(bus.WordCount), 32'd0);
  endtask

  // Checks the current write cycle, then advances one clock.
  task automatic chk_write(input string tag, input logic [31:0] addr, input logic [7:0] data);
    chk({tag, ".we"},    32'(bus.MemWe),     32'd1);
    chk({tag, ".addr"},  bus.MemAddr,        addr);
    chk({tag, ".data"},  32'(bus.MemData),   32'(data));
    chk({tag, ".ready"}, 32'(bus.WordReady), 32'd0);
    chk({tag, ".busy"},  32'(bus.Busy),      32'd1);
    tick();
  endtask

  // Expects to be in ACCEPT; handshakes one word and checks its four byte writes.
  task automatic send_word(input string tag, input logic [31:0] w, input logic last,
                           input logic [31:0] base);
    chk({tag, ".acc_ready"}, 32'(bus.WordReady), 32'd1);
    bus.WordValid = 1'b1;
    bus.WordData  = w;
    bus.WordLast  = last;
    tick();
    bus.WordValid = 1'b0;
    bus.WordLast  = 1'b0;
    for (int j = 0; j < 4; j++) begin
      chk_write(tag, base + 32'(j), w[31-8*j -: 8]);
    end
  endtask

  task automatic do_start();
    bus.Start = 1'b1;
    tick();
    bus.Start = 1'b0;
  endtask

  initial begin
    logic [31:0] w;
    checks = 0;
    errors = 0;
    rst           = 1'b1;
    bus.Start     = 1'b0;
    bus.WordValid = 1'b0;
    bus.WordData  = '0;
    bus.WordLast  = 1'b0;
    tick();
    tick();
    chk_reset_outputs("reset");
    rst = 1'b0;
    tick();
    chk_reset_outputs("idle");

    // Single word, explicit bytes.
    do_start();
    chk("t1.busy", 32'(bus.Busy), 32'd1);
    chk("t1.we0",  32'(bus.MemWe), 32'd0);
    bus.WordValid = 1'b1;
    bus.WordData  = 32'h8C010004;
    bus.WordLast  = 1'b1;
    tick();
    bus.WordValid = 1'b0;
    bus.WordLast  = 1'b0;
    chk_write("t1.b0", 32'd0, 8'h8C);
    chk_write("t1.b1", 32'd1, 8'h01);
    chk_write("t1.b2", 32'd2, 8'h00);
    chk_write("t1.b3", 32'd3, 8'h04);
    chk("t1.done", 32'(bus.Done),      32'd1);
    chk("t1.cnt",  32'(bus.WordCount), 32'd1);
    chk("t1.busy", 32'(bus.Busy),      32'd0);
    chk("t1.we",   32'(bus.MemWe),     32'd0);
    chk("t1.rdy",  32'(bus.WordReady), 32'd0);

    // Three words, Last on the third.
    do_start();
    chk("t2.cnt0",  32'(bus.WordCount), 32'd0);
    chk("t2.done0", 32'(bus.Done),      32'd0);
    send_word("t2.w0", 32'h20080005, 1'b0, 32'd0);
    chk("t2.we_gap", 32'(bus.MemWe), 32'd0);
    send_word("t2.w1", 32'h21090001, 1'b0, 32'd4);
    send_word("t2.w2", 32'hAC090008, 1'b1, 32'd8);
    chk("t2.done", 32'(bus.Done),      32'd1);
    chk("t2.cnt",  32'(bus.WordCount), 32'd3);

    // Fill memory with WordValid held high throughout.
    do_start();
    bus.WordValid = 1'b1;
    bus.WordLast  = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w = {8'(i), 8'hA5, ~8'(i), 8'h3C};
      chk("t3.ready", 32'(bus.WordReady), 32'd1);
      bus.WordData = w;
      tick();
      for (int j = 0; j < 4; j++) begin
        chk_write("t3.fill", 32'(4 * i + j), w[31-8*j -: 8]);
      end
    end
    chk("t3.done", 32'(bus.Done),      32'd1);
    chk("t3.cnt",  32'(bus.WordCount), 32'd32);
    chk("t3.addr_last", bus.MemAddr,   32'd127);
    tick();
    chk("t3.ovf",   32'(bus.Overflow),  32'd1);
    chk("t3.we",    32'(bus.MemWe),     32'd0);
    chk("t3.rdy",   32'(bus.WordReady), 32'd0);
    bus.WordValid = 1'b0;
    tick();
    chk("t3.ovf_sticky", 32'(bus.Overflow), 32'd1);
    do_start();
    chk("t3.ovf_clr",  32'(bus.Overflow),  32'd0);
    chk("t3.cnt_clr",  32'(bus.WordCount), 32'd0);
    chk("t3.done_clr", 32'(bus.Done),      32'd0);

    // Idle gaps in ACCEPT, then a word offered during WRITE waits for WordReady.
    for (int i = 0; i < 7; i++) begin
      chk("t4.gap_ready", 32'(bus.WordReady), 32'd1);
      chk("t4.gap_we",    32'(bus.MemWe),     32'd0);
      chk("t4.gap_busy",  32'(bus.Busy),      32'd1);
      tick();
    end
    bus.WordValid = 1'b1;
    bus.WordData  = 32'h11223344;
    tick();
    bus.WordData = 32'h55667788;
    bus.WordLast = 1'b1;
    chk_write("t4.a0", 32'd0, 8'h11);
    chk_write("t4.a1", 32'd1, 8'h22);
    chk_write("t4.a2", 32'd2, 8'h33);
    chk_write("t4.a3", 32'd3, 8'h44);
    chk("t4.ready_back", 32'(bus.WordReady), 32'd1);
    tick();
    bus.WordValid = 1'b0;
    bus.WordLast  = 1'b0;
    chk_write("t4.b0", 32'd4, 8'h55);
    chk_write("t4.b1", 32'd5, 8'h66);
    chk_write("t4.b2", 32'd6, 8'h77);
    chk_write("t4.b3", 32'd7, 8'h88);
    chk("t4.cnt", 32'(bus.WordCount), 32'd2);

    // Reset on the second write cycle.
    do_start();
    bus.WordValid = 1'b1;
    bus.WordData  = 32'h12345678;
    tick();
    bus.WordValid = 1'b0;
    chk_write("t5.b0", 32'd0, 8'h12);
    chk("t5.b1_addr", bus.MemAddr,      32'd1);
    chk("t5.b1_data", 32'(bus.MemData), 32'h34);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_reset_outputs("t5.rst");
    do_start();
    send_word("t5.new", 32'hDEADBEEF, 1'b1, 32'd0);
    chk("t5.done", 32'(bus.Done),      32'd1);
    chk("t5.cnt",  32'(bus.WordCount), 32'd1);

    // Start with WordValid in IDLE, then Start during WRITE.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.Start     = 1'b1;
    bus.WordValid = 1'b1;
    bus.WordData  = 32'hCAFEF00D;
    bus.WordLast  = 1'b1;
    tick();
    bus.Start = 1'b0;
    chk("t6.no_hs_we",  32'(bus.MemWe),     32'd0);
    chk("t6.no_hs_rdy", 32'(bus.WordReady), 32'd1);
    tick();
    bus.WordValid = 1'b0;
    bus.WordLast  = 1'b0;
    chk_write("t6.b0", 32'd0, 8'hCA);
    bus.Start = 1'b1;
    chk_write("t6.b1", 32'd1, 8'hFE);
    bus.Start = 1'b0;
    chk_write("t6.b2", 32'd2, 8'hF0);
    chk_write("t6.b3", 32'd3, 8'h0D);
    chk("t6.done", 32'(bus.Done),      32'd1);
    chk("t6.cnt",  32'(bus.WordCount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
